// File: rtl/register_file_pkg.sv
// Shared pipeline types for the RV32I register file: register ids, data words
// and the hardwired-zero register id.
package register_file_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int REG_COUNT  = 2 ** ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] register_id_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

  localparam register_id_t ZERO_REG = '0;

  function automatic logic is_zero_reg(input register_id_t id);
    return id == ZERO_REG;
  endfunction

endpackage

// File: rtl/register_file_if.sv
// Decode-stage register file bus: stall, read addresses, write-back and
// registered operands. The master drives addresses, the slave returns data.
interface register_file_if
  import register_file_pkg::*;
  ();

  logic         hold;
  register_id_t read1_id;
  register_id_t read2_id;
  logic         write_en;
  register_id_t write_id;
  data_t        write_data;
  data_t        read1_data;
  data_t        read2_data;

  modport master (
    output hold, read1_id, read2_id, write_en, write_id, write_data,
    input  read1_data, read2_data
  );

  modport slave (
    input  hold, read1_id, read2_id, write_en, write_id, write_data,
    output read1_data, read2_data
  );

endinterface

// File: rtl/register_file_read_port.sv
// One registered read port: stall-aware address capture, x0 forcing and
// write-first bypass from the write-back port.
module register_file_read_port
  import register_file_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         hold_i,
  input  register_id_t rd_id_i,
  input  logic         write_en_i,
  input  register_id_t write_id_i,
  input  data_t        write_data_i,
  input  data_t        regs_i [REG_COUNT],
  output data_t        rd_data_o
);

  register_id_t cap_q, cap_d;
  register_id_t eff_id;
  data_t        data_q, data_d;

  always_comb begin
    eff_id = hold_i ? cap_q : rd_id_i;
    // Holding re-captures the same id, so the capture register just follows eff_id.
    cap_d  = eff_id;
    if (is_zero_reg(eff_id)) begin
      data_d = '0;
    end else if (write_en_i && (write_id_i == eff_id)) begin
      data_d = write_data_i;
    end else begin
      data_d = regs_i[eff_id];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_q  <= ZERO_REG;
      data_q <= '0;
    end else begin
      cap_q  <= cap_d;
      data_q <= data_d;
    end
  end

  assign rd_data_o = data_q;

endmodule

// File: rtl/register_file.sv
// RV32I integer register file: 32 x 32-bit array with x0 hardwired to zero,
// one write-back port and two registered, bypassed read ports.
module register_file
  import register_file_pkg::*;
(
  input logic           clk,
  input logic           rst_n,
  register_file_if.slave bus
);

  data_t                regs_q [REG_COUNT];
  logic [REG_COUNT-1:0] wr_hit;

  // x0 never decodes as a write target, so its entry stays at reset value.
  generate
    for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_wr_decode
      if (gi == 0) begin : g_zero
        assign wr_hit[gi] = 1'b0;
      end else begin : g_reg
        assign wr_hit[gi] = bus.write_en && (bus.write_id == register_id_t'(gi));
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < REG_COUNT; i++) begin
        if (wr_hit[i]) begin
          regs_q[i] <= bus.write_data;
        end
      end
    end
  end

  register_file_read_port u_read1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .hold_i       (bus.hold),
    .rd_id_i      (bus.read1_id),
    .write_en_i   (bus.write_en),
    .write_id_i   (bus.write_id),
    .write_data_i (bus.write_data),
    .regs_i       (regs_q),
    .rd_data_o    (bus.read1_data)
  );

  register_file_read_port u_read2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .hold_i       (bus.hold),
    .rd_id_i      (bus.read2_id),
    .write_en_i   (bus.write_en),
    .write_id_i   (bus.write_id),
    .write_data_i (bus.write_data),
    .regs_i       (regs_q),
    .rd_data_o    (bus.read2_data)
  );

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: directed vector table with hand-derived expectations,
// then a random regression against a reference model, both via a scoreboard queue.
module tb_register_file;
  import register_file_pkg::*;

  logic clk;
  logic rst_n;

  register_file_if bus ();

  register_file dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst_n;
    logic         hold;
    register_id_t r1;
    register_id_t r2;
    logic         we;
    register_id_t wid;
    data_t        wdata;
    data_t        exp1;
    data_t        exp2;
    string        name;
  } vec_t;

  typedef struct {
    data_t exp1;
    data_t exp2;
    string name;
  } sb_t;

  sb_t   sb_q[$];
  int    checks = 0;
  int    errors = 0;

  // Reference model state
  data_t        m_regs [REG_COUNT];
  register_id_t m_cap1, m_cap2;

  function automatic data_t model_val(input register_id_t a, input logic we,
                                      input register_id_t wid, input data_t wd);
    if (a == 5'd0) return '0;
    if (we && wid == a) return wd;
    return m_regs[a];
  endfunction

  // Advances the model by one edge and returns the outputs that edge produces.
  task automatic model_step(input logic rn, input logic hd, input register_id_t r1,
                            input register_id_t r2, input logic we, input register_id_t wid,
                            input data_t wd, output data_t e1, output data_t e2);
    register_id_t eff1, eff2;
    if (!rn) begin
      e1 = '0;
      e2 = '0;
      for (int i = 0; i < REG_COUNT; i++) m_regs[i] = '0;
      m_cap1 = '0;
      m_cap2 = '0;
    end else begin
      eff1 = hd ? m_cap1 : r1;
      eff2 = hd ? m_cap2 : r2;
      e1 = model_val(eff1, we, wid, wd);
      e2 = model_val(eff2, we, wid, wd);
      m_cap1 = eff1;
      m_cap2 = eff2;
      if (we && wid != 5'd0) m_regs[wid] = wd;
    end
  endtask

  task automatic check_out();
    sb_t s;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: no expected entry for output cycle");
      return;
    end
    s = sb_q.pop_front();
    if (bus.read1_data !== s.exp1) begin
      errors++;
      $display("FAIL %s read1_data: got %h expected %h", s.name, bus.read1_data, s.exp1);
    end
    checks++;
    if (bus.read2_data !== s.exp2) begin
      errors++;
      $display("FAIL %s read2_data: got %h expected %h", s.name, bus.read2_data, s.exp2);
    end
  endtask

  // Drives one cycle of stimulus on the negedge, waits for the edge, then checks.
  task automatic drive_cycle(input logic rn, input logic hd, input register_id_t r1,
                             input register_id_t r2, input logic we, input register_id_t wid,
                             input data_t wd, input data_t e1, input data_t e2,
                             input string name);
    sb_t s;
    rst_n          = rn;
    bus.hold       = hd;
    bus.read1_id   = r1;
    bus.read2_id   = r2;
    bus.write_en   = we;
    bus.write_id   = wid;
    bus.write_data = wd;
    s.exp1 = e1;
    s.exp2 = e2;
    s.name = name;
    sb_q.push_back(s);
    @(posedge clk);
    @(negedge clk);
    check_out();
  endtask

  vec_t vecs[$];

  function automatic vec_t mk(input logic rn, input logic hd, input int r1, input int r2,
                              input logic we, input int wid, input data_t wd,
                              input data_t e1, input data_t e2, input string name);
    vec_t v;
    v.rst_n = rn; v.hold = hd;
    v.r1 = register_id_t'(r1); v.r2 = register_id_t'(r2);
    v.we = we; v.wid = register_id_t'(wid); v.wdata = wd;
    v.exp1 = e1; v.exp2 = e2; v.name = name;
    return v;
  endfunction

  initial begin
    data_t e1, e2;
    logic rn, hd, we;
    register_id_t r1, r2, wid;
    data_t wd;

    rst_n = 1'b0;
    bus.hold = 1'b0; bus.read1_id = '0; bus.read2_id = '0;
    bus.write_en = 1'b0; bus.write_id = '0; bus.write_data = '0;
    for (int i = 0; i < REG_COUNT; i++) m_regs[i] = '0;
    m_cap1 = '0; m_cap2 = '0;
    @(negedge clk);

    //            rst hold r1 r2 we wid wdata          exp1           exp2
    vecs.push_back(mk(0, 0, 0,  0,  0, 0, 32'h0,        32'h0,        32'h0,        "reset0"));
    vecs.push_back(mk(0, 0, 0,  0,  1, 5, 32'h1111,     32'h0,        32'h0,        "reset1"));
    vecs.push_back(mk(1, 0, 5,  31, 0, 0, 32'h0,        32'h0,        32'h0,        "reset_read"));
    vecs.push_back(mk(1, 0, 0,  0,  1, 5, 32'hDEADBEEF, 32'h0,        32'h0,        "write_x5"));
    vecs.push_back(mk(1, 0, 5,  0,  1, 0, 32'h1234,     32'hDEADBEEF, 32'h0,        "read_x5_wr_x0"));
    vecs.push_back(mk(1, 0, 0,  0,  0, 0, 32'h0,        32'h0,        32'h0,        "read_x0"));
    vecs.push_back(mk(1, 0, 7,  7,  1, 7, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, "bypass_x7"));
    vecs.push_back(mk(1, 0, 7,  5,  0, 0, 32'h0,        32'hA5A5A5A5, 32'hDEADBEEF, "array_x7"));
    vecs.push_back(mk(1, 0, 0,  0,  1, 3, 32'h11,       32'h0,        32'h0,        "write_x3"));
    vecs.push_back(mk(1, 0, 3,  5,  1, 9, 32'h99000099, 32'h11,       32'hDEADBEEF, "capture_x3"));
    vecs.push_back(mk(1, 1, 9,  7,  0, 0, 32'h0,        32'h11,       32'hDEADBEEF, "hold_keep"));
    vecs.push_back(mk(1, 1, 9,  7,  1, 3, 32'h22,       32'h22,       32'hDEADBEEF, "hold_wb"));
    vecs.push_back(mk(1, 1, 9,  7,  0, 0, 32'h0,        32'h22,       32'hDEADBEEF, "hold_after_wb"));
    vecs.push_back(mk(1, 0, 9,  7,  0, 0, 32'h0,        32'h99000099, 32'hA5A5A5A5, "hold_release"));
    vecs.push_back(mk(1, 0, 4,  0,  1, 4, 32'h55,       32'h55,       32'h0,        "capture_x4"));
    vecs.push_back(mk(1, 1, 9,  7,  0, 0, 32'h0,        32'h55,       32'h0,        "stall_x4"));
    vecs.push_back(mk(0, 1, 9,  7,  1, 4, 32'h66,       32'h0,        32'h0,        "reset_mid_stall"));
    vecs.push_back(mk(1, 1, 9,  7,  0, 0, 32'h0,        32'h0,        32'h0,        "post_reset_hold"));
    vecs.push_back(mk(1, 0, 4,  9,  0, 0, 32'h0,        32'h0,        32'h0,        "lost_write_x4"));
    vecs.push_back(mk(1, 0, 5,  7,  0, 0, 32'h0,        32'h0,        32'h0,        "cleared_regs"));

    foreach (vecs[k]) begin
      model_step(vecs[k].rst_n, vecs[k].hold, vecs[k].r1, vecs[k].r2, vecs[k].we,
                 vecs[k].wid, vecs[k].wdata, e1, e2);
      drive_cycle(vecs[k].rst_n, vecs[k].hold, vecs[k].r1, vecs[k].r2, vecs[k].we,
                  vecs[k].wid, vecs[k].wdata, vecs[k].exp1, vecs[k].exp2, vecs[k].name);
    end

    // Random regression; small id range half the time to force collisions.
    for (int c = 0; c < 10000; c++) begin
      rn  = ($urandom_range(0, 199) != 0);
      hd  = ($urandom_range(0, 3) == 0);
      we  = $urandom_range(0, 1);
      if ($urandom_range(0, 1) == 1) begin
        r1  = register_id_t'($urandom_range(0, 3));
        r2  = register_id_t'($urandom_range(0, 3));
        wid = register_id_t'($urandom_range(0, 3));
      end else begin
        r1  = register_id_t'($urandom_range(0, 31));
        r2  = register_id_t'($urandom_range(0, 31));
        wid = register_id_t'($urandom_range(0, 31));
      end
      wd = $urandom;
      model_step(rn, hd, r1, r2, we, wid, wd, e1, e2);
      drive_cycle(rn, hd, r1, r2, we, wid, wd, e1, e2, "random");
    end

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
